fpga_cfg_flash_prog_ctrl: RTL and testbench
===========================================

// Module: fpga_cfg_flash_prog_ctrl
// PURPOSE
//  Sequencer between the config-packet RAM writer and the BPI flash driver. On wr_flash_flag it
//  reads the 128x16 packet RAM (port B), issues erase/program word commands to the flash driver,
//  then pulses flag_clr to release the writer. Tracks pack order and reports done/error to host.
//  First pack (pack_cnt==1, config_reset) triggers a full erase of the bitstream region.
// PARAMETERS
//  FLASH_AW      24        flash word-address width
//  BASE_ADDR     24'h0     flash word address of pack 1, word 0
//  BLOCK_WORDS   65536     words per erase block (power of 2)
//  ERASE_BLOCKS  32        blocks erased on config_reset
//  WORDS_PER_PK  128       RAM words per pack (= RAM depth)
// PORTS
//  clk_166m        in   1    system clock; also drives RAM port B (clkb)
//  reset           in   1    synchronous, active-high
//  wr_flash_flag   in   1    level: a pack is resident in RAM
//  config_reset    in   1    level: current pack is pack 1 (start of new image)
//  pack_cnt        in   16   current pack number (1-based)
//  pack_num        in   16   total packs in image
//  flag_clr        out  1    1-cycle pulse: pack consumed, clears wr_flash_flag/config_reset
//  addrb           out  7    RAM read address
//  enb             out  1    RAM read enable
//  doutb           in   16   RAM read data, valid 1 cycle after enb
//  flash_cmd_valid out  1    command request to flash driver
//  flash_cmd_ready in   1    driver accepts command when valid&&ready
//  flash_cmd       out  2    0=NOP,1=ERASE_BLOCK,2=PROGRAM_WORD
//  flash_addr      out  FLASH_AW  word address (block base for erase)
//  flash_wdata     out  16   program data
//  flash_done      in   1    1-cycle pulse: accepted command finished
//  flash_err       in   1    1-cycle pulse: accepted command failed (replaces flash_done)
//  busy            out  1    FSM not in IDLE
//  cfg_done        out  1    sticky: last pack (pack_cnt==pack_num) programmed OK
//  cfg_err         out  1    sticky: flash error, pack out of order or pack_cnt invalid
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; exp_pack=1; flash_cmd=NOP.
//  FSM: IDLE -> CHECK when wr_flash_flag=1 and not in post-clear guard cycle.
//   CHECK: if config_reset: exp_pack<=1, cfg_done<=0, cfg_err<=0, blk<=0 -> ERASE_REQ.
//          elif pack_cnt==0 || pack_cnt>pack_num || pack_cnt!=exp_pack: cfg_err<=1 -> CLR.
//          else -> RD_REQ, widx<=0.
//   ERASE_REQ: valid=1, cmd=ERASE_BLOCK, addr=BASE_ADDR+blk*BLOCK_WORDS; on ready -> ERASE_WAIT.
//   ERASE_WAIT: done: blk==ERASE_BLOCKS-1 ? RD_REQ(widx=0) : blk++ ,ERASE_REQ. err -> ERR.
//   RD_REQ: enb=1, addrb=widx (1 cycle) -> RD_WAIT. RD_WAIT: capture doutb into wdata reg -> PROG_REQ.
//   PROG_REQ: valid=1, cmd=PROGRAM_WORD, addr=BASE_ADDR+{pack_cnt-1,7'b0}+widx, wdata held.
//          on ready -> PROG_WAIT.
//   PROG_WAIT: err -> ERR. done: widx==WORDS_PER_PK-1 -> PACK_OK; else widx++ -> RD_REQ.
//   PACK_OK: exp_pack<=pack_cnt+1; cfg_done<=(pack_cnt==pack_num) -> CLR.
//   ERR: cfg_err<=1 -> CLR.   CLR: flag_clr=1 (1 cycle) -> IDLE with 1-cycle guard (ignore flag).
//  Handshake: while valid=1, cmd/addr/wdata stable until ready; valid drops the cycle after accept.
//   flash_done/err before accept are ignored. Only one command outstanding.
//  Arithmetic: pack offset computed in FLASH_AW bits, wraps mod 2^FLASH_AW; pack_cnt/pack_num
//   latched in CHECK (upstream may not change them until flag_clr, but latch regardless).
//  Simultaneous done&&err: err wins. config_reset mid-pack is only sampled in CHECK.
//  wr_flash_flag dropping mid-operation: ignored; current pack completes, flag_clr still pulsed.
//  Reset mid-operation: immediate return to IDLE, valid deasserted, sticky status cleared.
//  Latency per word: RD_REQ+RD_WAIT+PROG_REQ(>=1)+PROG_WAIT(>=1) = >=4 cycles + driver time.
// STRUCTURE
//  Package fpga_cfg_pkg: FLASH_CMD_NOP/ERASE/PROG localparams, FSM state encodings, WORDS_PER_PK.
//  Single module, no sub-modules; FSM + widx(7b) + blk counter + exp_pack(16b) + wdata reg.
// TESTING (flash driver BFM: ready random 0-3 cycles, done 5 cycles after accept)
//  1 pack_cnt=1,pack_num=3,config_reset=1 -> 32 ERASE at 0,0x10000..0x1F0000, then 128 PROG
//    at 0..0x7F with bit-reversed RAM data, one flag_clr pulse, cfg_done=0, cfg_err=0.
//  2 packs 2,3 after test 1 -> PROG addrs 0x80..0xFF, 0x100..0x17F; cfg_done=1 after pack 3.
//  3 pack_cnt=3 after pack 1 (skip 2) -> no flash cmd, flag_clr pulse, cfg_err=1.
//  4 flash_err on word 5 of pack 2 -> no further cmds, cfg_err=1, flag_clr pulse, IDLE.
//  5 ready held low 50 cycles in PROG_REQ -> cmd/addr/wdata stable, valid held; no dup command.
//  6 reset asserted in ERASE_WAIT -> next cycle valid=0, busy=0, cfg_* = 0, exp_pack=1.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared constants and FSM encoding for the configuration-flash programming sequencer.
package fpga_cfg_pkg;

  localparam int WORDS_PER_PK = 128;
  localparam int WIDX_W       = $clog2(WORDS_PER_PK);

  localparam logic [1:0] FLASH_CMD_NOP   = 2'd0;
  localparam logic [1:0] FLASH_CMD_ERASE = 2'd1;
  localparam logic [1:0] FLASH_CMD_PROG  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ERASE_REQ,
    ST_ERASE_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_PROG_REQ,
    ST_PROG_WAIT,
    ST_PACK_OK,
    ST_ERR,
    ST_CLR
  } state_e;

endpackage

// File: rtl/fpga_cfg_flash_prog_ctrl.sv
// Moves one 128-word config pack from packet RAM into BPI flash, erasing the image
// region first when the pack starts a new image, and tracks pack order for the host.
module fpga_cfg_flash_prog_ctrl
  import fpga_cfg_pkg::*;
#(
  parameter int                  FLASH_AW     = 24,
  parameter logic [FLASH_AW-1:0] BASE_ADDR    = '0,
  parameter int                  BLOCK_WORDS  = 65536,
  parameter int                  ERASE_BLOCKS = 32
) (
  input  logic                clk_166m,
  input  logic                reset,
  input  logic                wr_flash_flag,
  input  logic                config_reset,
  input  logic [15:0]         pack_cnt,
  input  logic [15:0]         pack_num,
  output logic                flag_clr,
  output logic [6:0]          addrb,
  output logic                enb,
  input  logic [15:0]         doutb,
  output logic                flash_cmd_valid,
  input  logic                flash_cmd_ready,
  output logic [1:0]          flash_cmd,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic [15:0]         flash_wdata,
  input  logic                flash_done,
  input  logic                flash_err,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int                BLK_W     = (ERASE_BLOCKS > 1) ? $clog2(ERASE_BLOCKS) : 1;
  localparam int                BLK_SHIFT = $clog2(BLOCK_WORDS);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(ERASE_BLOCKS - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS_PER_PK - 1);

  state_e              state;
  logic                guard;
  logic [WIDX_W-1:0]   widx;
  logic [BLK_W-1:0]    blk;
  logic [15:0]         exp_pack;
  logic [15:0]         pack_q;
  logic [15:0]         pnum_q;

  logic [WIDX_W-1:0]   widx_nxt;
  logic [BLK_W-1:0]    blk_nxt;
  logic [FLASH_AW-1:0] erase_nxt_addr;
  logic [FLASH_AW-1:0] prog_addr;

  assign widx_nxt       = widx + WIDX_W'(1);
  assign blk_nxt        = blk + BLK_W'(1);
  assign erase_nxt_addr = BASE_ADDR + (FLASH_AW'(blk_nxt) << BLK_SHIFT);
  // Pack offset is formed at full flash width so it wraps mod 2^FLASH_AW.
  assign prog_addr      = BASE_ADDR + (FLASH_AW'(pack_q - 16'd1) << WIDX_W) + FLASH_AW'(widx);

  always_ff @(posedge clk_166m) begin
    if (reset) begin
      state           <= ST_IDLE;
      guard           <= 1'b0;
      widx            <= '0;
      blk             <= '0;
      exp_pack        <= 16'd1;
      pack_q          <= '0;
      pnum_q          <= '0;
      flag_clr        <= 1'b0;
      addrb           <= '0;
      enb             <= 1'b0;
      flash_cmd_valid <= 1'b0;
      flash_cmd       <= FLASH_CMD_NOP;
      flash_addr      <= '0;
      flash_wdata     <= '0;
      busy            <= 1'b0;
      cfg_done        <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      // NOTE: all outputs are registers written with <=; these defaults make the
      // single-cycle strobes self-clearing without any combinational output logic.
      flag_clr <= 1'b0;
      enb      <= 1'b0;
      guard    <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (wr_flash_flag && !guard) begin
            busy  <= 1'b1;
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          pack_q <= pack_cnt;
          pnum_q <= pack_num;
          if (config_reset) begin
            exp_pack        <= 16'd1;
            cfg_done        <= 1'b0;
            cfg_err         <= 1'b0;
            blk             <= '0;
            flash_cmd_valid <= 1'b1;
            flash_cmd       <= FLASH_CMD_ERASE;
            flash_addr      <= BASE_ADDR;
            state           <= ST_ERASE_REQ;
          end else if (pack_cnt == 16'd0 || pack_cnt > pack_num || pack_cnt != exp_pack) begin
            cfg_err  <= 1'b1;
            flag_clr <= 1'b1;
            state    <= ST_CLR;
          end else begin
            widx  <= '0;
            addrb <= '0;
            enb   <= 1'b1;
            state <= ST_RD_REQ;
          end
        end

        ST_ERASE_REQ: begin
          if (flash_cmd_ready) begin
            flash_cmd_valid <= 1'b0;
            flash_cmd       <= FLASH_CMD_NOP;
            state           <= ST_ERASE_WAIT;
          end
        end

        ST_ERASE_WAIT: begin
          if (flash_err) begin
            state <= ST_ERR;
          end else if (flash_done) begin
            if (blk == BLK_LAST) begin
              widx  <= '0;
              addrb <= '0;
              enb   <= 1'b1;
              state <= ST_RD_REQ;
            end else begin
              blk             <= blk_nxt;
              flash_cmd_valid <= 1'b1;
              flash_cmd       <= FLASH_CMD_ERASE;
              flash_addr      <= erase_nxt_addr;
              state           <= ST_ERASE_REQ;
            end
          end
        end

        ST_RD_REQ: state <= ST_RD_WAIT;

        ST_RD_WAIT: begin
          flash_wdata     <= doutb;
          flash_cmd_valid <= 1'b1;
          flash_cmd       <= FLASH_CMD_PROG;
          flash_addr      <= prog_addr;
          state           <= ST_PROG_REQ;
        end

        ST_PROG_REQ: begin
          if (flash_cmd_ready) begin
            flash_cmd_valid <= 1'b0;
            flash_cmd       <= FLASH_CMD_NOP;
            state           <= ST_PROG_WAIT;
          end
        end

        ST_PROG_WAIT: begin
          if (flash_err) begin
            state <= ST_ERR;
          end else if (flash_done) begin
            if (widx == WIDX_LAST) begin
              state <= ST_PACK_OK;
            end else begin
              widx  <= widx_nxt;
              addrb <= widx_nxt;
              enb   <= 1'b1;
              state <= ST_RD_REQ;
            end
          end
        end

        ST_PACK_OK: begin
          exp_pack <= pack_q + 16'd1;
          cfg_done <= (pack_q == pnum_q);
          flag_clr <= 1'b1;
          state    <= ST_CLR;
        end

        ST_ERR: begin
          cfg_err  <= 1'b1;
          flag_clr <= 1'b1;
          state    <= ST_CLR;
        end

        // The writer clears wr_flash_flag one cycle late, so skip it for one IDLE cycle.
        ST_CLR: begin
          guard <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_flash_prog_ctrl.sv
// Randomised bench: flash-driver BFM, packet-RAM model and a command-list reference
// model that predicts every accepted flash command and the final host status per pack.
module tb_fpga_cfg_flash_prog_ctrl;
  import fpga_cfg_pkg::*;

  localparam int AW = 24;

  logic          clk_166m = 1'b0;
  logic          reset    = 1'b1;
  logic          wr_flash_flag = 1'b0;
  logic          config_reset  = 1'b0;
  logic [15:0]   pack_cnt = '0;
  logic [15:0]   pack_num = '0;
  logic          flag_clr;
  logic [6:0]    addrb;
  logic          enb;
  logic [15:0]   doutb;
  logic          flash_cmd_valid;
  logic          flash_cmd_ready;
  logic [1:0]    flash_cmd;
  logic [AW-1:0] flash_addr;
  logic [15:0]   flash_wdata;
  logic          flash_done;
  logic          flash_err;
  logic          busy;
  logic          cfg_done;
  logic          cfg_err;

  fpga_cfg_flash_prog_ctrl #(
    .FLASH_AW    (AW),
    .BASE_ADDR   (24'h0),
    .BLOCK_WORDS (65536),
    .ERASE_BLOCKS(32)
  ) dut (
    .clk_166m       (clk_166m),
    .reset          (reset),
    .wr_flash_flag  (wr_flash_flag),
    .config_reset   (config_reset),
    .pack_cnt       (pack_cnt),
    .pack_num       (pack_num),
    .flag_clr       (flag_clr),
    .addrb          (addrb),
    .enb            (enb),
    .doutb          (doutb),
    .flash_cmd_valid(flash_cmd_valid),
    .flash_cmd_ready(flash_cmd_ready),
    .flash_cmd      (flash_cmd),
    .flash_addr     (flash_addr),
    .flash_wdata    (flash_wdata),
    .flash_done     (flash_done),
    .flash_err      (flash_err),
    .busy           (busy),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err)
  );

  always #3 clk_166m = ~clk_166m;

  typedef struct {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } cmd_t;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ram [WORDS_PER_PK];
  cmd_t        exp_q[$];
  cmd_t        log_q[$];
  int          clr_cnt = 0;

  int m_exp  = 1;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;

  int acc_idx  = 0;
  int inj_idx  = -1;
  int hold_idx = -1;
  int done_cnt = 0;
  int rdy_wait = -1;
  bit inj_now  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] bitrev(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  task automatic fill_ram(input bit rev);
    for (int i = 0; i < WORDS_PER_PK; i++)
      ram[i] = rev ? bitrev(16'(i)) : 16'($urandom);
  endtask

  // Packet RAM port B: registered read, data one cycle after enb.
  always @(posedge clk_166m) if (enb) doutb <= ram[addrb];

  // Reference model: the list of commands one pack must produce, and the resulting status.
  task automatic model_pack(input bit cr, input int pc, input int pn, input int inj);
    bit   ok;
    cmd_t c;
    exp_q.delete();
    ok = 1'b1;
    if (cr) begin
      m_exp  = 1;
      m_done = 1'b0;
      m_err  = 1'b0;
      for (int b = 0; b < 32; b++) begin
        c.cmd  = FLASH_CMD_ERASE;
        c.addr = AW'(b * 65536);
        c.data = '0;
        exp_q.push_back(c);
      end
    end else if (pc == 0 || pc > pn || pc != m_exp) begin
      m_err = 1'b1;
      ok    = 1'b0;
    end
    if (ok) begin
      for (int i = 0; i < WORDS_PER_PK; i++) begin
        c.cmd  = FLASH_CMD_PROG;
        c.addr = AW'((pc - 1) * 128 + i);
        c.data = ram[i];
        exp_q.push_back(c);
      end
      if (inj >= 0) begin
        while (exp_q.size() > inj + 1) void'(exp_q.pop_back());
        m_err = 1'b1;
      end else begin
        m_exp  = pc + 1;
        m_done = (pc == pn);
      end
    end
  endtask

  // Flash driver BFM: ready after 0-3 cycles (or a forced long stall), done 5 cycles after accept.
  initial begin
    flash_cmd_ready = 1'b0;
    flash_done      = 1'b0;
    flash_err       = 1'b0;
    forever begin
      @(negedge clk_166m);
      flash_done      = 1'b0;
      flash_err       = 1'b0;
      flash_cmd_ready = 1'b0;
      if (reset) begin
        done_cnt = 0;
        rdy_wait = -1;
        continue;
      end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          flash_done = 1'b1;
          flash_err  = inj_now;
        end
      end
      if (flash_cmd_valid) begin
        if (rdy_wait < 0) rdy_wait = (acc_idx == hold_idx) ? 50 : int'($urandom_range(3, 0));
        if (rdy_wait == 0) begin
          flash_cmd_ready = 1'b1;
          rdy_wait        = -1;
          done_cnt        = 5;
          inj_now         = (acc_idx == inj_idx);
          acc_idx++;
        end else begin
          rdy_wait--;
        end
      end
    end
  end

  // Compare process: every accepted command against the model, and request stability while stalled.
  initial begin
    bit   stall;
    cmd_t prev;
    cmd_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk_166m);
      #1;
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_valid", 32'(flash_cmd_valid), 32'd1);
        check("hold_cmd",   32'(flash_cmd),   32'(prev.cmd));
        check("hold_addr",  32'(flash_addr),  32'(prev.addr));
        check("hold_wdata", 32'(flash_wdata), 32'(prev.data));
      end
      if (flag_clr) clr_cnt++;
      if (flash_cmd_valid && flash_cmd_ready) begin
        e.cmd  = flash_cmd;
        e.addr = flash_addr;
        e.data = flash_wdata;
        log_q.push_back(e);
        check("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("cmd_code", 32'(flash_cmd),  32'(e.cmd));
          check("cmd_addr", 32'(flash_addr), 32'(e.addr));
          if (e.cmd == FLASH_CMD_PROG) check("cmd_wdata", 32'(flash_wdata), 32'(e.data));
        end
      end
      stall     = flash_cmd_valid && !flash_cmd_ready;
      prev.cmd  = flash_cmd;
      prev.addr = flash_addr;
      prev.data = flash_wdata;
    end
  end

  task automatic run_pack(input bit cr, input int pc, input int pn, input int inj, input int hold);
    bit seen;
    int drop_delay;
    model_pack(cr, pc, pn, inj);
    log_q.delete();
    clr_cnt  = 0;
    acc_idx  = 0;
    inj_idx  = inj;
    hold_idx = hold;
    @(negedge clk_166m);
    #2;
    config_reset  = cr;
    pack_cnt      = 16'(pc);
    pack_num      = 16'(pn);
    wr_flash_flag = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
      @(negedge clk_166m);
      #2;
      if (flag_clr) seen = 1'b1;
    end
    check("flag_clr_seen", 32'(seen), 32'd1);
    // Sometimes hold the flag into the post-clear cycle, as a slow writer would.
    drop_delay = ($urandom_range(1, 0) != 0) ? 2 : 0;
    repeat (drop_delay) @(negedge clk_166m);
    #2;
    wr_flash_flag = 1'b0;
    config_reset  = 1'b0;
    repeat (10) @(negedge clk_166m);
    #2;
    check("flag_clr_pulses", 32'(clr_cnt), 32'd1);
    check("idle_busy",       32'(busy), 32'd0);
    check("cmds_left",       32'(exp_q.size()), 32'd0);
    check("cfg_done",        32'(cfg_done), 32'(m_done));
    check("cfg_err",         32'(cfg_err),  32'(m_err));
    inj_idx  = -1;
    hold_idx = -1;
  endtask

  // Start a pack, assert reset once the command at index after_acc is outstanding.
  task automatic reset_mid(input bit cr, input int pc, input int pn, input int after_acc);
    bit reached;
    model_pack(cr, pc, pn, -1);
    acc_idx = 0;
    @(negedge clk_166m);
    #2;
    config_reset  = cr;
    pack_cnt      = 16'(pc);
    pack_num      = 16'(pn);
    wr_flash_flag = 1'b1;
    reached = 1'b0;
    for (int cyc = 0; cyc < 5000 && !reached; cyc++) begin
      @(negedge clk_166m);
      #2;
      if (acc_idx >= after_acc && done_cnt > 0 && done_cnt <= 3) reached = 1'b1;
    end
    check("reached_wait", 32'(reached), 32'd1);
    reset = 1'b1;
    @(negedge clk_166m);
    #2;
    check("rst_valid",    32'(flash_cmd_valid), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_cfg_err",  32'(cfg_err),  32'd0);
    check("rst_flag_clr", 32'(flag_clr), 32'd0);
    wr_flash_flag = 1'b0;
    config_reset  = 1'b0;
    exp_q.delete();
    m_exp  = 1;
    m_done = 1'b0;
    m_err  = 1'b0;
    @(negedge clk_166m);
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk_166m);
  endtask

  initial begin
    int sel;
    int pc;

    repeat (3) @(negedge clk_166m);
    #2;
    check("reset_flag_clr", 32'(flag_clr),        32'd0);
    check("reset_enb",      32'(enb),             32'd0);
    check("reset_valid",    32'(flash_cmd_valid), 32'd0);
    check("reset_cmd",      32'(flash_cmd),       32'(FLASH_CMD_NOP));
    check("reset_addr",     32'(flash_addr),      32'd0);
    check("reset_busy",     32'(busy),            32'd0);
    check("reset_cfg_done", 32'(cfg_done),        32'd0);
    check("reset_cfg_err",  32'(cfg_err),         32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_166m);

    // Image start: full erase then pack 1 with bit-reversed RAM contents.
    fill_ram(1'b1);
    run_pack(1'b1, 1, 3, -1, -1);
    check("t1_cmd_count", 32'(log_q.size()), 32'd160);
    if (log_q.size() == 160) begin
      check("t1_erase0_addr",  32'(log_q[0].addr),   32'h000000);
      check("t1_erase1_addr",  32'(log_q[1].addr),   32'h010000);
      check("t1_erase31_addr", 32'(log_q[31].addr),  32'h1F0000);
      check("t1_prog0_data",   32'(log_q[32].data),  32'h0000);
      check("t1_prog1_data",   32'(log_q[33].data),  32'h8000);
      check("t1_prog127_addr", 32'(log_q[159].addr), 32'h00007F);
      check("t1_prog127_data", 32'(log_q[159].data), 32'hFE00);
    end
    check("t1_cfg_done", 32'(cfg_done), 32'd0);

    // Packs 2 and 3; word 10 of pack 2 sees ready held low for 50 cycles.
    fill_ram(1'b0);
    run_pack(1'b0, 2, 3, -1, 10);
    fill_ram(1'b0);
    run_pack(1'b0, 3, 3, -1, -1);
    if (log_q.size() == 128) begin
      check("t2_first_addr", 32'(log_q[0].addr),   32'h000100);
      check("t2_last_addr",  32'(log_q[127].addr), 32'h00017F);
    end
    check("t2_cfg_done", 32'(cfg_done), 32'd1);

    // New image, then pack 2 skipped.
    fill_ram(1'b0);
    run_pack(1'b1, 1, 3, -1, -1);
    run_pack(1'b0, 3, 3, -1, -1);
    check("t3_no_cmds", 32'(log_q.size()), 32'd0);
    check("t3_cfg_err", 32'(cfg_err), 32'd1);

    // New image, flash error on word 5 of pack 2.
    fill_ram(1'b0);
    run_pack(1'b1, 1, 3, -1, -1);
    fill_ram(1'b0);
    run_pack(1'b0, 2, 3, 5, -1);
    check("t4_cmd_count", 32'(log_q.size()), 32'd6);
    check("t4_cfg_err",   32'(cfg_err), 32'd1);

    // Random mix of in-order, skipped, zero and out-of-range pack numbers.
    for (int k = 0; k < 6; k++) begin
      sel = int'($urandom_range(3, 0));
      case (sel)
        0:       pc = 0;
        1:       pc = m_exp;
        2:       pc = m_exp + 1;
        default: pc = 4;
      endcase
      fill_ram(1'b0);
      run_pack(1'b0, pc, 3, -1, -1);
    end

    // Reset while programming clears the sticky error.
    check("err_before_reset", 32'(cfg_err), 32'(m_err));
    fill_ram(1'b0);
    reset_mid(1'b0, m_exp, m_exp, 3);

    // Reset during erase, then pack 1 without config_reset proves exp_pack returned to 1.
    reset_mid(1'b1, 1, 3, 3);
    fill_ram(1'b0);
    run_pack(1'b0, 1, 1, -1, -1);
    check("t6_cmd_count", 32'(log_q.size()), 32'd128);
    check("t6_cfg_done",  32'(cfg_done), 32'd1);
    check("t6_cfg_err",   32'(cfg_err),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
